// File: rtl/multdiv_unit.sv
// Multicycle signed 32-bit multiplier (radix-2 Booth) and restoring divider for the execute stage.
// A start pulse in IDLE latches the operands; the result and a one-cycle RDY appear 33 edges later.
module multdiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_operandA,
    input  logic [DATA_WIDTH-1:0] data_operandB,
    input  logic                  ctrl_MULT,
    input  logic                  ctrl_DIV,
    output logic [DATA_WIDTH-1:0] data_result,
    output logic                  data_exception,
    output logic                  data_resultRDY,
    output logic                  busy
);
    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ZERO     = {W{1'b0}};
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state_r;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic                   op_div_r;
    logic [W-1:0]           mcand_r;
    logic [W:0]             acc_r;
    logic [W-1:0]           low_r;
    logic                   q1_r;
    logic [W-1:0]           rem_r;
    logic [W-1:0]           dvs_r;
    logic                   neg_r;
    logic                   div_zero_r;
    logic                   div_ovf_r;

    logic [2*W+1:0]         booth_s;
    logic [2*W-1:0]         div_s;
    logic                   mul_exc_s;
    logic [W-1:0]           quo_s;

    function automatic logic [W-1:0] negate(input logic [W-1:0] v);
        negate = (~v) + ONE;
    endfunction

    function automatic logic [W-1:0] abs_val(input logic [W-1:0] v);
        if (v[W-1]) begin
            abs_val = negate(v);
        end else begin
            abs_val = v;
        end
    endfunction

    // The 33-bit accumulator keeps the add/subtract of the most negative multiplicand from overflowing.
    // The returned vector is already the shifted {acc, multiplier, q-1} triple.
    function automatic logic [2*W+1:0] booth_step(input logic [W:0]   acc,
                                                  input logic [W-1:0] mq,
                                                  input logic         q1,
                                                  input logic [W-1:0] m);
        logic [W:0] m_ext;
        logic [W:0] sum;
        m_ext = {m[W-1], m};
        case ({mq[0], q1})
            2'b01:   sum = acc + m_ext;
            2'b10:   sum = acc - m_ext;
            default: sum = acc;
        endcase
        booth_step = {sum[W], sum, mq};
    endfunction

    // Remainder stays below the divisor, so the shifted trial value always fits in W+1 bits.
    function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                                input logic [W-1:0] quo,
                                                input logic [W-1:0] dvs);
        logic [W:0] shifted;
        logic [W:0] diff;
        shifted = {rem, quo[W-1]};
        diff    = shifted - {1'b0, dvs};
        if (shifted >= {1'b0, dvs}) begin
            div_step = {diff[W-1:0], quo[W-2:0], 1'b1};
        end else begin
            div_step = {shifted[W-1:0], quo[W-2:0], 1'b0};
        end
    endfunction

    assign booth_s   = booth_step(acc_r, low_r, q1_r, mcand_r);
    assign div_s     = div_step(rem_r, low_r, dvs_r);
    assign mul_exc_s = (acc_r[W-1:0] != {W{low_r[W-1]}});
    assign quo_s     = neg_r ? negate(low_r) : low_r;

    // Control FSM, datapath iteration and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            cnt_r          <= CNT_ZERO;
            op_div_r       <= 1'b0;
            mcand_r        <= ZERO;
            acc_r          <= {(W+1){1'b0}};
            low_r          <= ZERO;
            q1_r           <= 1'b0;
            rem_r          <= ZERO;
            dvs_r          <= ZERO;
            neg_r          <= 1'b0;
            div_zero_r     <= 1'b0;
            div_ovf_r      <= 1'b0;
            data_result    <= ZERO;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ctrl_MULT ^ ctrl_DIV) begin
                        cnt_r    <= CNT_ZERO;
                        busy     <= 1'b1;
                        op_div_r <= ctrl_DIV;
                        if (ctrl_MULT) begin
                            state_r <= MUL;
                            mcand_r <= data_operandA;
                            low_r   <= data_operandB;
                            acc_r   <= {(W+1){1'b0}};
                            q1_r    <= 1'b0;
                        end else begin
                            state_r    <= DIV;
                            low_r      <= abs_val(data_operandA);
                            dvs_r      <= abs_val(data_operandB);
                            rem_r      <= ZERO;
                            neg_r      <= data_operandA[W-1] ^ data_operandB[W-1];
                            div_zero_r <= (data_operandB == ZERO);
                            div_ovf_r  <= (data_operandA == MIN_NEG) && (data_operandB == ALL_ONES);
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MUL: begin
                    {acc_r, low_r, q1_r} <= booth_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_STEP) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= MUL;
                    end
                end
                DIV: begin
                    {rem_r, low_r} <= div_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_STEP) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= DIV;
                    end
                end
                DONE: begin
                    if (!op_div_r) begin
                        data_result    <= low_r;
                        data_exception <= mul_exc_s;
                    end else if (div_zero_r) begin
                        data_result    <= ZERO;
                        data_exception <= 1'b1;
                    end else begin
                        data_result    <= quo_s;
                        data_exception <= div_ovf_r;
                    end
                    data_resultRDY <= 1'b1;
                    busy           <= 1'b0;
                    state_r        <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit: signed multiply/divide vectors, latency,
// busy/start rules, asynchronous reset abort and back-to-back operation.
module tb_multdiv_unit;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    int n_start = 0;

    multdiv_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the start is sampled on the following posedge (edge N).
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic mul, input logic div);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = mul;
        ctrl_DIV = div;
        @(posedge clock);
        #1;
        n_start = edge_cnt;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
    endtask

    task automatic wait_rdy(input string tag);
        for (int i = 0; i < 45; i++) begin
            @(negedge clock);
            if (data_resultRDY) break;
        end
        check_val({tag, "_latency"}, 32'(edge_cnt - n_start), 32'd33);
    endtask

    task automatic watch_no_rdy(input string tag, input int n);
        int seen = 0;
        repeat (n) begin
            @(negedge clock);
            if (data_resultRDY) seen++;
        end
        check_val(tag, 32'(seen), 32'd0);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic mul, input logic div,
                         input logic [31:0] exp_res, input logic exp_exc, input string tag);
        start_op(a, b, mul, div);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_rdy(tag);
        check_val({tag, "_result"}, data_result, exp_res);
        check_val({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
        @(negedge clock);
        check_val({tag, "_rdy_width"}, {31'd0, data_resultRDY}, 32'd0);
        check_val({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_result", data_result, 32'd0);
        check_val("rst_exc", {31'd0, data_exception}, 32'd0);
        check_val("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        do_op(32'd7,          32'hFFFFFFFD, 1'b1, 1'b0, 32'hFFFFFFEB, 1'b0, "mul_small");
        do_op(32'h00010000,   32'h00010000, 1'b1, 1'b0, 32'h00000000, 1'b1, "mul_ovf");
        do_op(32'h80000000,   32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, 1'b1, "mul_min_neg1");
        do_op(32'h7FFFFFFF,   32'd1,        1'b1, 1'b0, 32'h7FFFFFFF, 1'b0, "mul_max_1");
        do_op(32'h80000000,   32'h80000000, 1'b1, 1'b0, 32'h00000000, 1'b1, "mul_min_min");
        do_op(32'h80000000,   32'd1,        1'b1, 1'b0, 32'h80000000, 1'b0, "mul_min_1");
        do_op(32'hFFFFFFF9,   32'd2,        1'b0, 1'b1, 32'hFFFFFFFD, 1'b0, "div_m7_2");
        do_op(32'd100,        32'hFFFFFFF6, 1'b0, 1'b1, 32'hFFFFFFF6, 1'b0, "div_100_m10");
        do_op(32'h80000000,   32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b1, "div_ovf");
        do_op(32'h12345678,   32'd0,        1'b0, 1'b1, 32'h00000000, 1'b1, "div_zero");
        do_op(32'd0,          32'd5,        1'b0, 1'b1, 32'h00000000, 1'b0, "div_0_5");
        do_op(32'h80000000,   32'd2,        1'b0, 1'b1, 32'hC0000000, 1'b0, "div_min_2");

        // A divide request mid-multiply must be ignored.
        start_op(32'd3, 32'd5, 1'b1, 1'b0);
        repeat (9) @(negedge clock);
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        check_val("ign_busy", {31'd0, busy}, 32'd1);
        wait_rdy("ign");
        check_val("ign_result", data_result, 32'd15);
        check_val("ign_exc", {31'd0, data_exception}, 32'd0);
        watch_no_rdy("ign_extra_rdy", 40);

        // Both start lines together start nothing.
        ctrl_MULT = 1'b1;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        #1;
        check_val("both_busy", {31'd0, busy}, 32'd0);
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        watch_no_rdy("both_no_rdy", 40);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clock);
        start_op(32'd6, 32'd7, 1'b1, 1'b0);
        while (edge_cnt - n_start < 20) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_val("abort_result", data_result, 32'd0);
        check_val("abort_exc", {31'd0, data_exception}, 32'd0);
        check_val("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        watch_no_rdy("abort_no_rdy", 40);
        do_op(32'd6, 32'd7, 1'b1, 1'b0, 32'd42, 1'b0, "after_abort");

        // Start accepted during the RDY cycle of the previous operation.
        start_op(32'd100, 32'd7, 1'b0, 1'b1);
        wait_rdy("b2b_first");
        check_val("b2b_first_result", data_result, 32'd14);
        start_op(32'h7FFFFFFF, 32'd1, 1'b1, 1'b0);
        check_val("b2b_rdy_drop", {31'd0, data_resultRDY}, 32'd0);
        check_val("b2b_busy", {31'd0, busy}, 32'd1);
        wait_rdy("b2b_second");
        check_val("b2b_second_result", data_result, 32'h7FFFFFFF);
        check_val("b2b_second_exc", {31'd0, data_exception}, 32'd0);
        @(negedge clock);
        check_val("b2b_rdy_width", {31'd0, data_resultRDY}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
